// File: rtl/io_mmio_ctrl_if.sv
// Bus interface for io_mmio_ctrl: single-cycle MIPS data-bus port in the I/O window.
// Handshake: there is no valid/ready pair. A write takes effect on the clock edge
// where pWrite is high; a read returns pReadData combinationally in the same cycle
// pRead is high, and its side effect (RX FIFO pop) lands on that cycle's clock edge.
interface io_mmio_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              pRead;
    logic              pWrite;
    logic [2:0]        addr;
    logic [DATA_W-1:0] pWriteData;
    logic [DATA_W-1:0] pReadData;

    modport master (
        output pRead, pWrite, addr, pWriteData,
        input  pReadData
    );

    modport slave (
        input  pRead, pWrite, addr, pWriteData,
        output pReadData
    );
endinterface

// File: rtl/io_mmio_ctrl.sv
// Memory-mapped I/O controller: debounced buttons, switch-capture RX FIFO,
// staged LED output and status/control registers.
// Optional feature macro: IO_MMIO_IRQ_EN adds a registered irq output enabled by CTRL bit2.
module io_mmio_ctrl #(
    parameter int SW_W       = 16,
    parameter int LED_W      = 12,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int DB_CYCLES  = 16
) (
    input  logic             clk,
    input  logic             reset,
    io_mmio_ctrl_if.slave    bus,
    input  logic             buttonL,
    input  logic             buttonR,
    input  logic [SW_W-1:0]  switch,
`ifdef IO_MMIO_IRQ_EN
    output logic             irq,
`endif
    output logic [LED_W-1:0] led
);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = PTR_W + 1;
    localparam int DBC_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DBC_W-1:0]  DBC_MAX = DBC_W'(DB_CYCLES - 1);
    localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(FIFO_DEPTH);

    // Index 0 = buttonL (LED commit), index 1 = buttonR (switch capture).
    logic [1:0]        r_btn_s1, r_btn_s2, r_btn_db, r_btn_dq;
    logic [DBC_W-1:0]  r_db_cnt [2];
    logic [SW_W-1:0]   r_sw_s1, r_sw_s2;
    logic [1:0]        w_pulse;

    logic [SW_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
    logic [FCNT_W-1:0] r_count;
    logic              r_overflow;

    logic [LED_W-1:0]  r_led_stage, r_led;
    logic              r_led_done;

    logic              w_empty, w_full;
    logic              w_led_wr, w_ctrl_wr, w_flush, w_clr_ovf;
    logic              w_pop, w_push_ok, w_drop;
    logic [DATA_W-1:0] w_rdata;
    logic              w_unused_wdata;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_CNT);
    assign w_led_wr  = bus.pWrite && (bus.addr == 3'b001);
    assign w_ctrl_wr = bus.pWrite && (bus.addr == 3'b011);
    assign w_flush   = w_ctrl_wr && bus.pWriteData[1];
    assign w_clr_ovf = w_ctrl_wr && bus.pWriteData[0];
    assign w_pop     = bus.pRead && (bus.addr == 3'b010) && !w_empty;
    // Flush swallows any push in the same cycle, so a flushed push never drops/overflows.
    assign w_push_ok = w_pulse[1] && !w_flush && (!w_full || w_pop);
    assign w_drop    = w_pulse[1] && !w_flush && w_full && !w_pop;
    assign w_pulse   = r_btn_db & ~r_btn_dq;
    assign w_unused_wdata = ^bus.pWriteData;

    // Two-flop synchronisers, per-button debounce counters and edge-detect history.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
            r_btn_db <= '0;
            r_btn_dq <= '0;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
        end else begin
            r_btn_s1 <= {buttonR, buttonL};
            r_btn_s2 <= r_btn_s1;
            r_btn_dq <= r_btn_db;
            r_sw_s1  <= switch;
            r_sw_s2  <= r_sw_s1;
            for (int i = 0; i < 2; i++) begin
                if (r_btn_s2[i] == r_btn_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DBC_MAX) begin
                    r_btn_db[i] <= r_btn_s2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // RX FIFO pointers and occupancy; flush takes priority over push and pop.
    always_ff @(posedge clk) begin
        if (reset || w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // RX FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (!reset && w_push_ok) r_mem[r_wr_ptr] <= r_sw_s2;
    end

    // Sticky overflow: a dropped sample beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset)          r_overflow <= 1'b0;
        else if (w_drop)    r_overflow <= 1'b1;
        else if (w_clr_ovf) r_overflow <= 1'b0;
    end

    // LED staging and commit; a bus write clears led_done even when a commit lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_led_stage <= '0;
            r_led       <= '0;
            r_led_done  <= 1'b0;
        end else begin
            if (w_pulse[0]) begin
                r_led      <= r_led_stage;
                r_led_done <= 1'b1;
            end
            if (w_led_wr) begin
                r_led_stage <= bus.pWriteData[LED_W-1:0];
                r_led_done  <= 1'b0;
            end
        end
    end

`ifdef IO_MMIO_IRQ_EN
    logic r_irq_en, r_irq;

    // Interrupt enable from CTRL bit2; irq follows the FIFO/overflow state one cycle late.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_irq_en <= bus.pWriteData[2];
            r_irq <= r_irq_en && (!w_empty || r_overflow);
        end
    end
    assign irq = r_irq;
`endif

    // Combinational read mux; everything is zero-extended, unmapped or idle reads give 0.
    always_comb begin
        w_rdata = '0;
        if (bus.pRead) begin
            case (bus.addr)
                3'b000: begin
                    w_rdata[0]   = r_led_done;
                    w_rdata[1]   = !w_empty;
                    w_rdata[2]   = w_full;
                    w_rdata[3]   = r_overflow;
                    w_rdata[7:4] = 4'(r_count);
                end
                3'b010:  if (!w_empty) w_rdata[SW_W-1:0] = r_mem[r_rd_ptr];
                3'b100:  w_rdata[SW_W-1:0]  = r_sw_s2;
                3'b101:  w_rdata[LED_W-1:0] = r_led;
                default: w_rdata = '0;
            endcase
        end
    end

    assign bus.pReadData = w_rdata;
    assign led = r_led;
endmodule
